// File: rtl/config_pkg.sv
// Shared types and constants for the framed limit-configuration manager.
package config_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_HDR = 3'd1,
    ST_RECV     = 3'd2,
    ST_WAIT_CHK = 3'd3,
    ST_CHECK    = 3'd4,
    ST_COMMIT   = 3'd5,
    ST_DONE     = 3'd6,
    ST_ERRO     = 3'd7
  } state_t;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_RX       = 3'd1;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd2;
  localparam logic [2:0] ERR_CHECKSUM = 3'd3;
  localparam logic [2:0] ERR_ORDER    = 3'd4;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  function automatic int bytes_per_word(input int lim_w);
    return (lim_w + 7) / 8;
  endfunction

endpackage

// File: rtl/config_timeout_counter.sv
// Inter-byte idle counter: flags expiry once TIMEOUT_CYC-1 idle clocks have elapsed.
module config_timeout_counter #(
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC);

  logic [CW-1:0] cnt;

  assign expired = (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/config_manager_n.sv
// Parses one framed config packet into shadow words and commits them atomically.
// Optional build macro CFG_ORDER_CHECK_EN adds a non-decreasing temperature-limit check.
module config_manager_n
  import config_pkg::*;
#(
  parameter int         N_TEMP      = 7,
  parameter int         LIM_W       = 16,
  parameter int         TIMEOUT_CYC = 5000000,
  parameter logic [7:0] HEADER      = DEFAULT_HEADER
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    receber_config,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  input  logic                    rx_erro,
  output logic [N_TEMP*LIM_W-1:0] temp_lim_flat,
  output logic [LIM_W-1:0]        umidade_lim,
  output logic                    pronto_config,
  output logic                    erro_config,
  output logic [2:0]              erro_codigo,
  output logic [2:0]              db_estado,
  output logic [7:0]              db_byte_count
);

  localparam int BPW  = bytes_per_word(LIM_W);
  localparam int WI_W = $clog2(N_TEMP + 1);

  state_t            state, state_next;
  logic [LIM_W-1:0]  shadow [0:N_TEMP];
  logic [LIM_W-1:0]  lim    [0:N_TEMP];
  logic [7:0]        acc, chk_byte, byte_count;
  logic [2:0]        byte_idx;
  logic [WI_W-1:0]   word_idx;
  logic [2:0]        err_code;
  logic              start, take_byte, take_chk, err_set;
  logic              waiting, expired, last_byte;

  assign waiting   = (state == ST_WAIT_HDR) || (state == ST_RECV) || (state == ST_WAIT_CHK);
  assign last_byte = (byte_idx == 3'(BPW - 1)) && (word_idx == WI_W'(N_TEMP));

  // Any accepted byte restarts the idle window; outside the receive states it stays parked at 0.
  config_timeout_counter #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (rx_valid || !waiting),
    .enable  (waiting),
    .expired (expired)
  );

`ifdef CFG_ORDER_CHECK_EN
  logic order_ok;
  always_comb begin
    order_ok = 1'b1;
    for (int k = 2; k <= N_TEMP; k++) begin
      if (shadow[WI_W'(k)] < shadow[WI_W'(k - 1)]) order_ok = 1'b0;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    take_byte  = 1'b0;
    take_chk   = 1'b0;
    err_set    = 1'b0;
    err_code   = ERR_NONE;
    case (state)
      ST_IDLE, ST_ERRO: begin
        if (receber_config) begin
          state_next = ST_WAIT_HDR;
          start      = 1'b1;
        end
      end
      ST_WAIT_HDR, ST_RECV, ST_WAIT_CHK: begin
        if (rx_valid && rx_erro) begin
          err_set  = 1'b1;
          err_code = ERR_RX;
        end else if (rx_valid) begin
          case (state)
            ST_WAIT_HDR: if (rx_data == HEADER) state_next = ST_RECV;
            ST_RECV: begin
              take_byte = 1'b1;
              if (last_byte) state_next = ST_WAIT_CHK;
            end
            default: begin
              take_chk   = 1'b1;
              state_next = ST_CHECK;
            end
          endcase
        end else if (expired) begin
          err_set  = 1'b1;
          err_code = ERR_TIMEOUT;
        end
      end
      ST_CHECK: begin
        if (chk_byte != acc) begin
          err_set  = 1'b1;
          err_code = ERR_CHECKSUM;
        end
`ifdef CFG_ORDER_CHECK_EN
        else if (!order_ok) begin
          err_set  = 1'b1;
          err_code = ERR_ORDER;
        end
`endif
        else state_next = ST_COMMIT;
      end
      ST_COMMIT: state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
    if (err_set) state_next = ST_ERRO;
  end

  // Big-endian shift; bytes beyond LIM_W fall off the top of the word.
  always_ff @(posedge clock) begin
    if (take_byte) shadow[word_idx] <= LIM_W'({shadow[word_idx], rx_data});
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc         <= '0;
      chk_byte    <= '0;
      byte_count  <= '0;
      byte_idx    <= '0;
      word_idx    <= '0;
      erro_config <= 1'b0;
      erro_codigo <= ERR_NONE;
      for (int i = 0; i <= N_TEMP; i++) lim[i] <= '0;
    end else begin
      if (start) begin
        acc         <= '0;
        byte_count  <= '0;
        byte_idx    <= '0;
        word_idx    <= '0;
        erro_config <= 1'b0;
        erro_codigo <= ERR_NONE;
      end
      if (take_byte) begin
        acc        <= acc ^ rx_data;
        byte_count <= byte_count + 8'd1;
        if (byte_idx == 3'(BPW - 1)) begin
          byte_idx <= '0;
          word_idx <= word_idx + WI_W'(1);
        end else begin
          byte_idx <= byte_idx + 3'd1;
        end
      end
      if (take_chk) chk_byte <= rx_data;
      if (err_set) begin
        erro_config <= 1'b1;
        erro_codigo <= err_code;
      end
      if (state == ST_COMMIT) begin
        for (int i = 0; i <= N_TEMP; i++) lim[i] <= shadow[i];
      end
    end
  end

  for (genvar k = 0; k < N_TEMP; k++) begin : g_flat
    assign temp_lim_flat[k*LIM_W +: LIM_W] = lim[k+1];
  end

  assign umidade_lim   = lim[0];
  assign pronto_config = (state == ST_DONE);
  assign db_estado     = state;
  assign db_byte_count = byte_count;

endmodule

// File: tb/tb_config_manager_n.sv
// Directed bench for config_manager_n: a 7x16-bit instance and a 3x12-bit instance.
module tb_config_manager_n;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;
  logic rc0, rv0, re0;
  logic [7:0] rd0;
  logic [111:0] tflat0;
  logic [15:0] um0;
  logic pr0, ec0;
  logic [2:0] cod0, st0;
  logic [7:0] bc0;

  logic rc1, rv1, re1;
  logic [7:0] rd1;
  logic [35:0] tflat1;
  logic [11:0] um1;
  logic pr1, ec1;
  logic [2:0] cod1, st1;
  logic [7:0] bc1;

  config_manager_n #(.N_TEMP(7), .LIM_W(16), .TIMEOUT_CYC(20), .HEADER(8'hA5)) u0 (
    .clock(clock), .reset(reset), .receber_config(rc0), .rx_data(rd0), .rx_valid(rv0),
    .rx_erro(re0), .temp_lim_flat(tflat0), .umidade_lim(um0), .pronto_config(pr0),
    .erro_config(ec0), .erro_codigo(cod0), .db_estado(st0), .db_byte_count(bc0)
  );

  config_manager_n #(.N_TEMP(3), .LIM_W(12), .TIMEOUT_CYC(20), .HEADER(8'hA5)) u1 (
    .clock(clock), .reset(reset), .receber_config(rc1), .rx_data(rd1), .rx_valid(rv1),
    .rx_erro(re1), .temp_lim_flat(tflat1), .umidade_lim(um1), .pronto_config(pr1),
    .erro_config(ec1), .erro_codigo(cod1), .db_estado(st1), .db_byte_count(bc1)
  );

  int tests = 0;
  int fails = 0;
  logic [15:0] w0 [8];
  logic [7:0]  pay0 [16];
  logic [7:0]  pay1 [8];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic send0(input logic [7:0] b, input logic e);
    @(negedge clock); rd0 = b; rv0 = 1'b1; re0 = e;
    @(negedge clock); rv0 = 1'b0; re0 = 1'b0;
  endtask

  task automatic send1(input logic [7:0] b);
    @(negedge clock); rd1 = b; rv1 = 1'b1;
    @(negedge clock); rv1 = 1'b0;
  endtask

  task automatic start0();
    @(negedge clock); rc0 = 1'b1;
    @(negedge clock); rc0 = 1'b0;
  endtask

  task automatic pack0();
    for (int k = 0; k < 8; k++) begin
      pay0[2*k]   = w0[k][15:8];
      pay0[2*k+1] = w0[k][7:0];
    end
  endtask

  function automatic logic [7:0] xor0();
    logic [7:0] x = 8'h00;
    for (int k = 0; k < 16; k++) x ^= pay0[k];
    return x;
  endfunction

  function automatic logic [7:0] xor1();
    logic [7:0] x = 8'h00;
    for (int k = 0; k < 8; k++) x ^= pay1[k];
    return x;
  endfunction

  task automatic frame0(input logic [7:0] chk);
    send0(8'hA5, 1'b0);
    for (int k = 0; k < 16; k++) send0(pay0[k], 1'b0);
    send0(chk, 1'b0);
  endtask

  // Called right after the checksum byte was sampled: pronto must rise on the third clock.
  task automatic expect_commit0(input string tag, input logic [15:0] um, input logic [111:0] fl);
    check({tag, "_chk_state"}, 128'(st0), 128'(4));
    check({tag, "_pronto_c1"}, 128'(pr0), 128'(0));
    tick();
    check({tag, "_pronto_c2"}, 128'(pr0), 128'(0));
    tick();
    check({tag, "_pronto_c3"}, 128'(pr0), 128'(1));
    check({tag, "_umidade"}, 128'(um0), 128'(um));
    check({tag, "_temps"}, 128'(tflat0), 128'(fl));
    check({tag, "_errflag"}, 128'(ec0), 128'(0));
    tick();
    check({tag, "_pronto_c4"}, 128'(pr0), 128'(0));
    check({tag, "_idle"}, 128'(st0), 128'(0));
  endtask

  initial begin
    reset = 1'b0;
    rc0 = 0; rv0 = 0; re0 = 0; rd0 = '0;
    rc1 = 0; rv1 = 0; re1 = 0; rd1 = '0;
    tick(); tick();
    check("rst_state", 128'(st0), 128'(0));
    check("rst_um", 128'(um0), 128'(0));
    check("rst_temps", 128'(tflat0), 128'(0));
    check("rst_pronto", 128'(pr0), 128'(0));
    check("rst_err", 128'({ec0, cod0}), 128'(0));
    check("rst_count", 128'(bc0), 128'(0));
    reset = 1'b1;
    tick();

    // T1: good frame, payload is 8 words x 2 bytes = 16 bytes
    w0 = '{16'h0320, 16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0050, 16'h0060, 16'h0070};
    pack0();
    check("t1_xor_const", 128'(xor0()), 128'(8'h23));
    start0();
    check("t1_wait_hdr", 128'(st0), 128'(1));
    frame0(8'h23);
    check("t1_count", 128'(bc0), 128'(16));
    expect_commit0("t1", 16'h0320, 112'h0070_0060_0050_0040_0030_0020_0010);

    // T2: corrupted checksum leaves committed limits untouched
    start0();
    frame0(8'h23 ^ 8'h01);
    tick();
    check("t2_state", 128'(st0), 128'(7));
    check("t2_err", 128'({ec0, cod0}), 128'({1'b1, 3'd3}));
    check("t2_pronto", 128'(pr0), 128'(0));
    check("t2_um", 128'(um0), 128'(16'h0320));
    check("t2_temps", 128'(tflat0), 128'(112'h0070_0060_0050_0040_0030_0020_0010));

    // T3: restart clears the error; mid-frame restart ignored; silence times out
    start0();
    check("t3_clear", 128'({ec0, cod0, st0}), 128'({1'b0, 3'd0, 3'd1}));
    send0(8'hA5, 1'b0);
    send0(8'h11, 1'b0);
    send0(8'h22, 1'b0);
    start0();
    check("t3_restart_ignored", 128'({st0, bc0}), 128'({3'd2, 8'd2}));
    send0(8'h33, 1'b0);
    send0(8'h44, 1'b0);
    check("t3_count", 128'(bc0), 128'(4));
    for (int i = 0; i < 19; i++) tick();
    check("t3_edge_alive", 128'(st0), 128'(2));
    tick();
    check("t3_timeout", 128'({st0, ec0, cod0}), 128'({3'd7, 1'b1, 3'd2}));

    // T4: rx_erro aborts with the byte discarded; junk before header is skipped
    start0();
    send0(8'hA5, 1'b0);
    for (int k = 0; k < 4; k++) send0(8'h5A, 1'b0);
    send0(8'h5A, 1'b1);
    check("t4_rxerr", 128'({st0, ec0, cod0}), 128'({3'd7, 1'b1, 3'd1}));
    check("t4_count", 128'(bc0), 128'(4));
    start0();
    send0(8'h00, 1'b0);
    send0(8'hFF, 1'b0);
    check("t4_junk", 128'({st0, bc0}), 128'({3'd1, 8'd0}));
    w0 = '{16'hBEEF, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600, 16'h0700};
    pack0();
    frame0(xor0());
    expect_commit0("t4", 16'hBEEF, 112'h0700_0600_0500_0400_0300_0200_0100);

    // T5: temp3 < temp2 with a valid checksum
    w0 = '{16'h1111, 16'h0010, 16'h0050, 16'h0030, 16'h0040, 16'h0050, 16'h0060, 16'h0070};
    pack0();
    start0();
    frame0(xor0());
`ifdef CFG_ORDER_CHECK_EN
    tick();
    check("t5_order_err", 128'({st0, ec0, cod0}), 128'({3'd7, 1'b1, 3'd4}));
    check("t5_um_kept", 128'(um0), 128'(16'hBEEF));
    check("t5_temps_kept", 128'(tflat0), 128'(112'h0700_0600_0500_0400_0300_0200_0100));
`else
    expect_commit0("t5", 16'h1111, 112'h0070_0060_0050_0040_0030_0050_0010);
`endif

    // T6: async reset in the middle of a frame, then the 3x12-bit instance
    start0();
    send0(8'hA5, 1'b0);
    send0(8'h01, 1'b0);
    send0(8'h02, 1'b0);
    send0(8'h03, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_state", 128'(st0), 128'(0));
    check("t6_rst_limits", 128'({um0, tflat0}), 128'(0));
    check("t6_rst_ctl", 128'({bc0, ec0, cod0, pr0}), 128'(0));
    @(negedge clock) reset = 1'b1;

    pay1 = '{8'hFA, 8'hBC, 8'hF1, 8'h23, 8'h04, 8'h56, 8'h07, 8'h89};
    @(negedge clock); rc1 = 1'b1;
    @(negedge clock); rc1 = 1'b0;
    send1(8'hA5);
    for (int k = 0; k < 8; k++) send1(pay1[k]);
    check("t6_n3_count", 128'(bc1), 128'(8));
    send1(xor1());
    check("t6_n3_chk", 128'(st1), 128'(4));
    tick(); tick();
    check("t6_n3_pronto", 128'(pr1), 128'(1));
    check("t6_n3_um", 128'(um1), 128'(12'hABC));
    check("t6_n3_temps", 128'(tflat1), 128'(36'h789_456_123));
    tick();
    check("t6_n3_idle", 128'({st1, pr1, ec1}), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
